// File: rtl/alu_hilo.sv
// rtl/alu_hilo.sv - HI/LO register unit with multi-cycle mul/div commit; optional ALU_HILO_BYPASS_EN
package alu_hilo_pkg;
    localparam int FUNC_W = 5;
    typedef logic [FUNC_W-1:0] alu_func_t;

    localparam alu_func_t ALU_ADD  = 5'd0;
    localparam alu_func_t ALU_SUB  = 5'd1;
    localparam alu_func_t ALU_AND  = 5'd2;
    localparam alu_func_t ALU_OR   = 5'd3;
    localparam alu_func_t ALU_XOR  = 5'd4;
    localparam alu_func_t ALU_SLT  = 5'd5;
    localparam alu_func_t ALU_MULS = 5'd16;
    localparam alu_func_t ALU_MULU = 5'd17;
    localparam alu_func_t ALU_DIVS = 5'd18;
    localparam alu_func_t ALU_DIVU = 5'd19;
    localparam alu_func_t ALU_MTLO = 5'd20;
    localparam alu_func_t ALU_MTHI = 5'd21;
    localparam alu_func_t ALU_MFLO = 5'd22;
    localparam alu_func_t ALU_MFHI = 5'd23;
endpackage

module alu_hilo #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = $clog2((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [alu_hilo_pkg::FUNC_W-1:0]  func,
    input  logic                             flush,
    input  logic [DATA_W-1:0]                res_lo,
    input  logic [DATA_W-1:0]                res_hi,
    output logic [DATA_W-1:0]                reg_lo,
    output logic [DATA_W-1:0]                reg_hi,
    output logic                             busy,
    output logic                             stall
);
    import alu_hilo_pkg::*;

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

`ifdef ALU_HILO_BYPASS_EN
    localparam bit BYPASS_OK = 1'b1;
`else
    localparam bit BYPASS_OK = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [DATA_W-1:0] lo, hi, pend_lo, pend_hi;
    logic [CNT_W-1:0]  cnt;

    logic is_mul, is_div, is_mtlo, is_mthi, is_mf, hilo_op;
    logic req, commit, accept;

    always_comb begin
        is_mul  = (func == ALU_MULS) || (func == ALU_MULU);
        is_div  = (func == ALU_DIVS) || (func == ALU_DIVU);
        is_mtlo = (func == ALU_MTLO);
        is_mthi = (func == ALU_MTHI);
        is_mf   = (func == ALU_MFLO) || (func == ALU_MFHI);
        hilo_op = is_mul || is_div || is_mtlo || is_mthi || is_mf;
        req     = in_valid && !flush && hilo_op;
        commit  = (state == PEND) && (cnt == '0);
        // Every HI/LO access waits out a pending result; bypass lets the commit cycle through.
        stall   = req && (state == PEND) && !(BYPASS_OK && commit);
        accept  = req && !stall;
        busy    = (state == PEND);
    end

    always_comb begin
        state_nxt = state;
        if (accept && (is_mul || is_div)) begin
            state_nxt = PEND;
        end else if (commit) begin
            state_nxt = IDLE;
        end
    end

`ifdef ALU_HILO_BYPASS_EN
    always_comb begin
        reg_lo = commit ? pend_lo : lo;
        reg_hi = commit ? pend_hi : hi;
    end
`else
    always_comb begin
        reg_lo = lo;
        reg_hi = hi;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lo      <= '0;
            hi      <= '0;
            pend_lo <= '0;
            pend_hi <= '0;
            cnt     <= '0;
        end else begin
            if (commit) begin
                lo <= pend_lo;
                hi <= pend_hi;
            end
            if ((state == PEND) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            // An accepted move lands after the commit so it wins on the shared edge.
            if (accept) begin
                if (is_mul || is_div) begin
                    pend_lo <= res_lo;
                    pend_hi <= res_hi;
                    cnt     <= is_mul ? MUL_LD : DIV_LD;
                end
                if (is_mtlo) begin
                    lo <= res_lo;
                end
                if (is_mthi) begin
                    hi <= res_hi;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_hilo.sv
// tb/tb_alu_hilo.sv - scoreboard bench for alu_hilo against a cycle-indexed reference model
module tb_alu_hilo;
    import alu_hilo_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;
`ifdef ALU_HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, in_valid, flush;
    alu_func_t   func;
    logic [31:0] res_lo, res_hi, reg_lo, reg_hi;
    logic        busy, stall;

    int nchecks = 0;
    int nerr    = 0;

    alu_hilo #(.DATA_W(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .func(func), .flush(flush),
        .res_lo(res_lo), .res_hi(res_hi), .reg_lo(reg_lo), .reg_hi(reg_hi),
        .busy(busy), .stall(stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        busy;
        logic        stall;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: architectural HI/LO plus at most one pending result with its commit edge.
    bit          m_valid = 0;
    logic [31:0] m_lo, m_hi, m_plo, m_phi;
    bit          m_pv;
    int          m_cedge;
    int          k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, k);
        end
    endtask

    function automatic bit is_hilo(input alu_func_t f);
        return f inside {ALU_MULS, ALU_MULU, ALU_DIVS, ALU_DIVU,
                         ALU_MTLO, ALU_MTHI, ALU_MFLO, ALU_MFHI};
    endfunction

    task automatic cycle(input bit rst, input bit v, input alu_func_t f, input bit fl,
                         input logic [31:0] rl, input logic [31:0] rh, output bit st_obs);
        exp_t e;
        bit   commit_now, rq, st, acc;
        reset = rst; in_valid = v; func = f; flush = fl; res_lo = rl; res_hi = rh;
        commit_now = m_pv && (m_cedge == k + 1);
        rq  = v && !fl && is_hilo(f);
        st  = rq && m_pv && !(BYP && commit_now);
        acc = rq && !st;
        if (m_valid) begin
            e.lo    = (BYP && commit_now) ? m_plo : m_lo;
            e.hi    = (BYP && commit_now) ? m_phi : m_hi;
            e.busy  = m_pv;
            e.stall = st;
            e.cyc   = k;
            sb.push_back(e);
        end
        @(negedge clock);
        st_obs = stall;
        @(posedge clock);
        if (rst) begin
            m_valid = 1; m_lo = 0; m_hi = 0; m_plo = 0; m_phi = 0; m_pv = 0; m_cedge = 0;
        end else if (m_valid) begin
            if (commit_now) begin
                m_lo = m_plo; m_hi = m_phi; m_pv = 0;
            end
            if (acc) begin
                if (f inside {ALU_MULS, ALU_MULU, ALU_DIVS, ALU_DIVU}) begin
                    m_pv = 1; m_plo = rl; m_phi = rh;
                    m_cedge = k + 1 + ((f inside {ALU_MULS, ALU_MULU}) ? MUL_LAT : DIV_LAT);
                end
                if (f == ALU_MTLO) m_lo = rl;
                if (f == ALU_MTHI) m_hi = rh;
            end
        end
        k++;
        #1;
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_reg_lo", reg_lo, e.lo);
            chk("sb_reg_hi", reg_hi, e.hi);
            chk("sb_busy",   {31'd0, busy},  {31'd0, e.busy});
            chk("sb_stall",  {31'd0, stall}, {31'd0, e.stall});
        end
    end

    alu_func_t funcs[10] = '{ALU_ADD, ALU_SUB, ALU_MULS, ALU_MULU, ALU_DIVS,
                             ALU_DIVU, ALU_MTLO, ALU_MTHI, ALU_MFLO, ALU_MFHI};

    initial begin
        bit st;
        int n;
        reset = 1; in_valid = 0; func = ALU_ADD; flush = 0; res_lo = 0; res_hi = 0;
        #1;
        cycle(1, 0, ALU_ADD, 0, 0, 0, st);

        // Preset lo, then reset clears it.
        cycle(0, 1, ALU_MTLO, 0, 32'hDEAD, 0, st);
        cycle(1, 0, ALU_ADD, 0, 0, 0, st);
        chk("rst_reg_lo", reg_lo, 32'h0);
        chk("rst_reg_hi", reg_hi, 32'h0);
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_stall",  {31'd0, stall}, 32'd0);

        cycle(0, 1, ALU_MTLO, 0, 32'h1234, 32'h5555, st);
        chk("mtlo_lo", reg_lo, 32'h1234);
        chk("mtlo_hi", reg_hi, 32'h0);
        cycle(0, 1, ALU_MTHI, 0, 32'h7777, 32'hABCD, st);
        chk("mthi_lo", reg_lo, 32'h1234);
        chk("mthi_hi", reg_hi, 32'hABCD);

        // Mulu then Mflo held until accepted.
        cycle(0, 1, ALU_MULU, 0, 32'd6, 32'd1, st);
        n = 0;
        do begin
            cycle(0, 1, ALU_MFLO, 0, 0, 0, st);
            if (st) n++;
        end while (st && n < 20);
        chk("mul_stall_cycles", n, BYP ? 2 : 3);
        chk("mul_lo", reg_lo, 32'd6);
        chk("mul_hi", reg_hi, 32'd1);

        // Divu then Mthi back-to-back.
        cycle(0, 1, ALU_DIVU, 0, 32'd7, 32'd2, st);
        n = 0;
        do begin
            cycle(0, 1, ALU_MTHI, 0, 0, 32'd9, st);
            if (st) n++;
        end while (st && n < 20);
        chk("div_stall_cycles", n, BYP ? 7 : 8);
        cycle(0, 0, ALU_ADD, 0, 0, 0, st);
        chk("div_lo", reg_lo, 32'd7);
        chk("div_hi", reg_hi, 32'd9);

        // Reset with cnt=1 drops the pending result.
        cycle(0, 1, ALU_MULU, 0, 32'hAAAA, 32'hBBBB, st);
        cycle(0, 0, ALU_ADD, 0, 0, 0, st);
        cycle(1, 0, ALU_ADD, 0, 0, 0, st);
        chk("rstpend_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, ALU_ADD, 0, 0, 0, st);
        chk("rstpend_lo", reg_lo, 32'h0);
        chk("rstpend_hi", reg_hi, 32'h0);

        cycle(0, 1, ALU_MTLO, 1, 32'h55, 0, st);
        chk("flush_mtlo_lo", reg_lo, 32'h0);

        cycle(0, 1, ALU_MULS, 0, 32'h11, 32'h22, st);
        cycle(0, 1, ALU_MFHI, 1, 0, 0, st);
        chk("flush_mf_stall", {31'd0, st}, 32'd0);
        cycle(0, 1, ALU_ADD, 0, 0, 0, st);
        chk("add_pend_stall", {31'd0, st}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, ALU_ADD, 0, 0, 0, st);

        for (int i = 0; i < 2500; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
                  funcs[$urandom_range(0, 9)], ($urandom_range(0, 9) == 0),
                  $urandom, $urandom, st);
        end

        in_valid = 0;
        repeat (2) @(negedge clock);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
